multiport_register_file: RTL
============================

// Module: multiport_register_file
// PURPOSE
//  Parametrised successor register file for the CPU datapath: READ_PORTS read ports and two write ports.
//  Reads are registered with write-to-read bypass, and entry 0 is hardwired to zero.
//  After reset, an init sequencer loads every entry i with value i, one entry per cycle.
//  Sits between decode (read addresses) and writeback (up to two results per cycle).
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  DEPTH       32  number of registers, power of two, >=2; ADDR_WIDTH = $clog2(DEPTH) (localparam)
//  READ_PORTS  2   number of read ports, 1..8
// PORTS
//  clock               in   1                        sole clock, all logic posedge
//  reset               in   1                        synchronous, active-high
//  ready               out  1                        1 = init complete, file usable
//  read_address        in   READ_PORTS*ADDR_WIDTH    port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  data_out            out  READ_PORTS*DATA_WIDTH    port p at [p*DATA_WIDTH +: DATA_WIDTH]
//  write_enable_0/1    in   1                        write strobe per write port
//  write_address_0/1   in   ADDR_WIDTH               write address per write port
//  write_data_in_0/1   in   DATA_WIDTH               write data per write port
//  write_collision     out  1                        registered pulse: both ports wrote same nonzero addr
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state<=INIT, init_idx<=0, ready<=0, data_out<=0, write_collision<=0.
//  - Storage is not cleared by reset itself; the INIT state loads it.
//  - INIT: each cycle registers[init_idx]<=init_idx (zero-extended), then init_idx++.
//    - On init_idx==DEPTH-1, state<=RUN and ready<=1 on that same edge.
//    - First usable cycle is DEPTH cycles after reset deasserts.
//    - During INIT, write ports are ignored, data_out is held at 0 and write_collision stays 0.
//  - Reset asserted mid-INIT or mid-RUN restarts INIT from index 0. Writes in the reset cycle are dropped.
//  - RUN writes: posedge, port k writes when write_enable_k=1 and write_address_k!=0.
//    - Address 0 writes are silently dropped; entry 0 always reads 0.
//    - Same address on both ports, both enabled: port 1 wins.
//    - If that address is nonzero, write_collision=1 for exactly one cycle, else 0.
//  - RUN reads: 1-cycle latency; data_out[p] at edge n+1 reflects read_address[p] sampled at edge n.
//    - Bypass: if read_address[p] matches an enabled nonzero write address in the same cycle,
//      data_out[p] gets the new write data (port 1 over port 0), never the stale entry.
//    - read_address[p]==0 gives 0.
//    - data_out holds its value otherwise; there is no read enable.
//  - FSM: INIT -> RUN when init_idx==DEPTH-1. RUN -> INIT only on reset. Encoding is a 1-bit enum.
// CONFIGURATION
//  REGFILE_DEBUG_PORT_EN defined:
//    - Adds read_address_debug (in, ADDR_WIDTH) and data_out_debug (out, DATA_WIDTH).
//    - data_out_debug follows the same clock, 1-cycle latency and bypass rules as a normal read port.
//    - Reset value of data_out_debug is 0, held at 0 in INIT.
//  REGFILE_DEBUG_PORT_EN undefined: both ports absent; no extra logic.
// STRUCTURE
//  regfile_pkg holds:
//    - typedef enum logic {RF_INIT, RF_RUN} rf_state_t
//    - default DATA_WIDTH/DEPTH/READ_PORTS constants
//    - function rf_bypass_select() for the port-1-over-port-0 priority
//  Sub-module regfile_read_port: one address-zero check + bypass compare + output register.
//    - Instantiated READ_PORTS times via generate, plus once more under REGFILE_DEBUG_PORT_EN.
//  Storage array, write logic, collision flag and init FSM stay in the top module.
// TESTING
//  1 Reset 1 cycle, then release: ready=0 for 32 cycles and 1 at cycle 32.
//    Reads of addresses 5 and 31 return 5 and 31.
//  2 After ready, write port 0 stores addr 7 = 0xDEADBEEF; next cycle read addr 7 on port 1
//    -> data_out port 1 = 0xDEADBEEF one cycle later.
//  3 Same cycle: write port 0 addr 3 = 0x11, port 1 addr 3 = 0x22, read addr 3.
//    -> data_out = 0x22 (bypass), write_collision=1 for one cycle, and a later read of 3 returns 0x22.
//  4 Write addr 0 = 0xFFFFFFFF on both ports -> read addr 0 returns 0, write_collision stays 0.
//  5 Reset asserted at init cycle 10 -> ready stays 0, init restarts;
//    ready rises 32 cycles after the second release and entry 12 reads 12.
//  6 With REGFILE_DEBUG_PORT_EN: write addr 9 = 0x1234 while read_address_debug=9
//    -> data_out_debug=0x1234 one cycle later. Without the macro, the build has no debug ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_DEPTH      = 32;
  localparam int RF_READ_PORTS = 2;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  // Source of the next value captured by a read port.
  typedef enum logic [1:0] {
    RF_SEL_ZERO,
    RF_SEL_ENTRY,
    RF_SEL_W0,
    RF_SEL_W1
  } rf_sel_t;

  // Entry 0 reads as zero regardless of any write to it. Otherwise a
  // same-cycle write to the read address is forwarded, with port 1 taking
  // priority over port 0 to match the storage update order.
  function automatic rf_sel_t rf_bypass_select(input logic addr_is_zero,
                                               input logic hit_0,
                                               input logic hit_1);
    rf_sel_t sel;
    if (addr_is_zero) sel = RF_SEL_ZERO;
    else if (hit_1)   sel = RF_SEL_W1;
    else if (hit_0)   sel = RF_SEL_W0;
    else              sel = RF_SEL_ENTRY;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with write-to-read bypass and zero entry 0.
// Latency: 1 cycle from read_address to data_out.
// Backpressure: none; data_out is held at 0 while run is low.
//
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   run                       1 once the file is initialised; 0 forces data_out to 0
//   read_address, entry_data  address and the raw storage word at that address
//   write_*_0 / write_*_1     same-cycle write ports, used for bypass
//   data_out                  registered read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(RF_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] entry_data,
  input  logic                  write_enable_0,
  input  logic [ADDR_WIDTH-1:0] write_address_0,
  input  logic [DATA_WIDTH-1:0] write_data_0,
  input  logic                  write_enable_1,
  input  logic [ADDR_WIDTH-1:0] write_address_1,
  input  logic [DATA_WIDTH-1:0] write_data_1,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic                  addr_is_zero;
  logic                  hit_0;
  logic                  hit_1;
  rf_sel_t               sel;
  logic [DATA_WIDTH-1:0] next_data;

  // A hit on address 0 is harmless: the zero check outranks both hits.
  assign addr_is_zero = (read_address == '0);
  assign hit_0        = write_enable_0 && (write_address_0 == read_address);
  assign hit_1        = write_enable_1 && (write_address_1 == read_address);

  always_comb begin
    next_data = '0;
    sel       = rf_bypass_select(addr_is_zero, hit_0, hit_1);
    case (sel)
      RF_SEL_W1:    next_data = write_data_1;
      RF_SEL_W0:    next_data = write_data_0;
      RF_SEL_ENTRY: next_data = entry_data;
      default:      next_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !run) data_out <= '0;
    else               data_out <= next_data;
  end

endmodule

// File: rtl/multiport_register_file.sv
// Register file, READ_PORTS registered read ports, two write ports, self-initialising.
// Latency: 1 cycle read; usable DEPTH cycles after reset deasserts (ready=1).
// Backpressure: none; writes are ignored and reads return 0 until ready.
//
// Ports: clock/reset (sync, active-high); ready; read_address/data_out packed per port;
//   write_enable_k/write_address_k/write_data_in_k for k=0,1; write_collision pulse.
// Optional REGFILE_DEBUG_PORT_EN adds read_address_debug/data_out_debug, an extra read port.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int READ_PORTS = RF_READ_PORTS
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               ready,
  input  logic [READ_PORTS*$clog2(DEPTH)-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0]   data_out,
  input  logic                               write_enable_0,
  input  logic [$clog2(DEPTH)-1:0]           write_address_0,
  input  logic [DATA_WIDTH-1:0]              write_data_in_0,
  input  logic                               write_enable_1,
  input  logic [$clog2(DEPTH)-1:0]           write_address_1,
  input  logic [DATA_WIDTH-1:0]              write_data_in_1,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [$clog2(DEPTH)-1:0]           read_address_debug,
  output logic [DATA_WIDTH-1:0]              data_out_debug,
`endif
  output logic                               write_collision
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] registers [DEPTH];
  rf_state_t             state;
  rf_state_t             state_next;
  logic [ADDR_WIDTH-1:0] init_idx;
  logic                  init_last;
  logic                  run;
  logic                  wr_0;
  logic                  wr_1;

  assign run       = (state == RF_RUN);
  assign init_last = (init_idx == ADDR_WIDTH'(DEPTH - 1));
  // Writes to address 0 never reach storage, and never count for bypass.
  assign wr_0      = run && write_enable_0 && (write_address_0 != '0);
  assign wr_1      = run && write_enable_1 && (write_address_1 != '0);

  always_comb begin
    state_next = state;
    if (state == RF_INIT && init_last) state_next = RF_RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= RF_INIT;
      init_idx        <= '0;
      ready           <= 1'b0;
      write_collision <= 1'b0;
    end else begin
      state           <= state_next;
      if (state == RF_INIT) init_idx <= init_idx + 1'b1;
      if (state == RF_INIT && init_last) ready <= 1'b1;
      write_collision <= wr_0 && wr_1 && (write_address_0 == write_address_1);
    end
  end

  // Storage has no reset; the INIT sweep loads it. Port 1 is assigned last
  // so it wins a same-address write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == RF_INIT) begin
        registers[init_idx] <= DATA_WIDTH'(init_idx);
      end else begin
        if (wr_0) registers[write_address_0] <= write_data_in_0;
        if (wr_1) registers[write_address_1] <= write_data_in_1;
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port (
      .clock          (clock),
      .reset          (reset),
      .run            (run),
      .read_address   (addr),
      .entry_data     (registers[addr]),
      .write_enable_0 (wr_0),
      .write_address_0(write_address_0),
      .write_data_0   (write_data_in_0),
      .write_enable_1 (wr_1),
      .write_address_1(write_address_1),
      .write_data_1   (write_data_in_1),
      .data_out       (data_out[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef REGFILE_DEBUG_PORT_EN
  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_debug_port (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .read_address   (read_address_debug),
    .entry_data     (registers[read_address_debug]),
    .write_enable_0 (wr_0),
    .write_address_0(write_address_0),
    .write_data_0   (write_data_in_0),
    .write_enable_1 (wr_1),
    .write_address_1(write_address_1),
    .write_data_1   (write_data_in_1),
    .data_out       (data_out_debug)
  );
`endif

endmodule
